// File: rtl/fm24clxx_i2c_target.sv
// I2C target modelling an FM24CL16B FRAM: 2 KiB array, page bits in the device address,
// sequential write and random/current/sequential read with no write delay.
//
// state      | meaning
// IDLE       | not addressed, waiting for START
// DEV_ADDR   | shifting in the device address byte
// ACK_DEV    | acknowledging the device address
// WORD_ADDR  | shifting in the word address byte
// ACK_WORD   | acknowledging the word address
// WRITE_DATA | shifting in a data byte to write
// ACK_WRITE  | acknowledging a written byte
// READ_DATA  | shifting out mem[pointer]
// ACK_READ   | waiting for the master's ACK/NACK
module fm24clxx_i2c_target #(
  parameter int       MEM_BYTES = 2048,
  parameter logic [3:0] DEV_ID  = 4'b1010,
  localparam int      AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_DEV_ADDR   = 4'd1;
  localparam logic [3:0] S_ACK_DEV    = 4'd2;
  localparam logic [3:0] S_WORD_ADDR  = 4'd3;
  localparam logic [3:0] S_ACK_WORD   = 4'd4;
  localparam logic [3:0] S_WRITE_DATA = 4'd5;
  localparam logic [3:0] S_ACK_WRITE  = 4'd6;
  localparam logic [3:0] S_READ_DATA  = 4'd7;
  localparam logic [3:0] S_ACK_READ   = 4'd8;

  logic          scl_s1, scl_s2, scl_d;
  logic          sda_s1, sda_s2, sda_d;
  logic          scl_rise, scl_fall, start_c, stop_c;
  logic [3:0]    state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    rd_byte;
  logic [7:0]    byte_in;
  logic [7:0]    mem_rd;
  logic [2:0]    page;
  logic          rw;
  logic          ack_phase;
  logic          mem_we;
  logic [AW-1:0] pointer;
  logic [7:0]    mem [MEM_BYTES];

  // Synchronisers reset to the idle-bus level so reset release cannot look like a START
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise = scl_s2 & ~scl_d;
  assign scl_fall = ~scl_s2 & scl_d;
  assign start_c  = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_c   = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign byte_in  = {shreg[6:0], sda_s2};
  assign mem_rd   = mem[pointer];
  assign mem_we   = (state == S_WRITE_DATA) && scl_rise && (bit_cnt == 4'd7);

  always_ff @(posedge clk) begin
    if (mem_we) mem[pointer] <= byte_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= 4'd0;
      shreg     <= 8'd0;
      rd_byte   <= 8'd0;
      page      <= 3'd0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
      pointer   <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'd0;
    end else begin
      wr_strobe <= 1'b0;
      if (start_c) begin
        state     <= S_DEV_ADDR;
        bit_cnt   <= 4'd0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else if (stop_c) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_DEV_ADDR: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (byte_in[7:4] == DEV_ID) begin
                  state     <= S_ACK_DEV;
                  page      <= byte_in[3:1];
                  rw        <= byte_in[0];
                  busy      <= 1'b1;
                  ack_phase <= 1'b0;
                end else begin
                  state <= S_IDLE;
                end
              end
            end
          end
          S_ACK_DEV, S_ACK_WORD, S_ACK_WRITE: begin
            // First falling edge pulls SDA for the ACK, second one ends the ACK bit
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= 4'd0;
                sda_oe    <= 1'b0;
                if (state == S_ACK_DEV && rw) begin
                  state   <= S_READ_DATA;
                  rd_byte <= mem_rd;
                  sda_oe  <= ~mem_rd[7];
                end else if (state == S_ACK_DEV) begin
                  state <= S_WORD_ADDR;
                end else begin
                  state <= S_WRITE_DATA;
                end
              end
            end
          end
          S_WORD_ADDR: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                pointer   <= AW'({page, byte_in});
                state     <= S_ACK_WORD;
                ack_phase <= 1'b0;
              end
            end
          end
          S_WRITE_DATA: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                wr_strobe <= 1'b1;
                wr_addr   <= pointer;
                wr_data   <= byte_in;
                pointer   <= pointer + AW'(1);
                state     <= S_ACK_WRITE;
                ack_phase <= 1'b0;
              end
            end
          end
          S_READ_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe    <= 1'b0;
                pointer   <= pointer + AW'(1);
                state     <= S_ACK_READ;
                ack_phase <= 1'b0;
              end else begin
                sda_oe <= ~rd_byte[~bit_cnt[2:0]];
              end
            end
          end
          S_ACK_READ: begin
            if (scl_rise) begin
              if (sda_s2) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end else begin
                ack_phase <= 1'b1;
              end
            end else if (scl_fall && ack_phase) begin
              state     <= S_READ_DATA;
              bit_cnt   <= 4'd0;
              ack_phase <= 1'b0;
              rd_byte   <= mem_rd;
              sda_oe    <= ~mem_rd[7];
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fm24clxx_i2c_target.sv
// Bench for fm24clxx_i2c_target: bit-banged I2C master against a byte-array model of the FRAM.
module tb_fm24clxx_i2c_target;
  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_oe, busy, wr_strobe;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;

  assign sda_bus = sda_m & ~sda_oe;

  fm24clxx_i2c_target dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_oe(sda_oe), .busy(busy), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  ref_mem [2048];
  logic [10:0] ref_ptr = 11'd0;
  logic [7:0]  wbuf [16];
  logic [7:0]  rbuf [16];
  logic [10:0] sq_a [$];
  logic [7:0]  sq_d [$];
  int          oe_viol = 0;
  logic        busy_seen = 1'b0;
  logic        oe_seen = 1'b0;
  logic        oe_prev = 1'b0;

  // Bus monitor: record write strobes and catch SDA being newly pulled while SCL is high
  always @(posedge clk) begin
    #1;
    if (wr_strobe) begin
      sq_a.push_back(wr_addr);
      sq_d.push_back(wr_data);
    end
    if (busy) busy_seen = 1'b1;
    if (sda_oe) oe_seen = 1'b1;
    if (sda_oe && !oe_prev && scl_m) oe_viol++;
    oe_prev = sda_oe;
  end

  task automatic qwait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; qwait(Q);
    scl_m = 1'b1; qwait(Q);
    sda_m = 1'b0; qwait(Q);
    scl_m = 1'b0; qwait(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; qwait(Q);
    scl_m = 1'b1; qwait(Q);
    sda_m = 1'b1; qwait(Q);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    sda_m = b;    qwait(Q);
    scl_m = 1'b1; qwait(Q);
    r = sda_bus;  qwait(Q);
    scl_m = 1'b0; qwait(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, r);
    ack = ~r;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(nack, r);
  endtask

  task automatic clear_mon();
    sq_a.delete();
    sq_d.delete();
    busy_seen = 1'b0;
    oe_seen = 1'b0;
  endtask

  task automatic wr_txn(input logic [10:0] a, input int n, output logic ok);
    logic ack;
    ok = 1'b1;
    bus_start();
    send_byte({4'hA, a[10:8], 1'b0}, ack); ok &= ack;
    send_byte(a[7:0], ack); ok &= ack;
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], ack); ok &= ack;
      ref_mem[a + 11'(i)] = wbuf[i];
    end
    bus_stop();
    ref_ptr = a + 11'(n);
  endtask

  task automatic rd_random(input logic [10:0] a, input int n, output logic ok);
    logic ack;
    ok = 1'b1;
    bus_start();
    send_byte({4'hA, a[10:8], 1'b0}, ack); ok &= ack;
    send_byte(a[7:0], ack); ok &= ack;
    bus_start();
    send_byte({4'hA, a[10:8], 1'b1}, ack); ok &= ack;
    for (int i = 0; i < n; i++) recv_byte(i == n - 1, rbuf[i]);
    bus_stop();
    ref_ptr = a + 11'(n);
  endtask

  task automatic rd_current(input int n, output logic ok);
    logic ack;
    bus_start();
    send_byte(8'hA1, ack);
    ok = ack;
    for (int i = 0; i < n; i++) recv_byte(i == n - 1, rbuf[i]);
    bus_stop();
    ref_ptr = ref_ptr + 11'(n);
  endtask

  task automatic test_reset();
    qwait(3);
    n_checks++;
    if ({sda_oe, busy, wr_strobe, wr_addr, wr_data} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got oe=%b busy=%b stb=%b addr=%h data=%h, want all zero",
               sda_oe, busy, wr_strobe, wr_addr, wr_data);
    end
    rst_n = 1'b1;
    qwait(Q);
  endtask

  task automatic test_fill();
    logic ok;
    clear_mon();
    for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
    wr_txn(11'h000, 16, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL fill_acks: got %b want 1", ok); end
    n_checks++;
    if (sq_a.size() != 16) begin
      n_fail++; $display("FAIL fill_strobe_count: got %0d want 16", sq_a.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (sq_a[i] !== 11'(i) || sq_d[i] !== wbuf[i]) begin
          n_fail++;
          $display("FAIL fill_strobe[%0d]: got %h/%h want %h/%h", i, sq_a[i], sq_d[i], 11'(i), wbuf[i]);
        end
      end
    end
  endtask

  task automatic test_write_single();
    logic ok;
    clear_mon();
    wbuf[0] = 8'hA5;
    wr_txn(11'h123, 1, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL single_acks: got %b want 1", ok); end
    n_checks++;
    if (sq_a.size() != 1 || sq_a[0] !== 11'h123 || sq_d[0] !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_strobe: got n=%0d addr=%h data=%h want n=1 123/a5",
               sq_a.size(), (sq_a.size() > 0) ? sq_a[0] : 11'h0, (sq_d.size() > 0) ? sq_d[0] : 8'h0);
    end
    n_checks++;
    if (busy_seen !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_busy: seen=%b after_stop=%b want 1/0", busy_seen, busy);
    end
  endtask

  task automatic test_random_read();
    logic ack, ok;
    logic [7:0] d;
    ok = 1'b1;
    bus_start();
    send_byte(8'hA2, ack); ok &= ack;
    send_byte(8'h23, ack); ok &= ack;
    bus_start();
    send_byte(8'hA3, ack); ok &= ack;
    recv_byte(1'b1, d);
    qwait(2);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rread_busy_after_nack: got %b want 0", busy); end
    bus_stop();
    ref_ptr = 11'h124;
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL rread_acks: got %b want 1", ok); end
    n_checks++;
    if (d !== ref_mem[11'h123]) begin
      n_fail++; $display("FAIL rread_data: got %h want %h", d, ref_mem[11'h123]);
    end
  endtask

  task automatic test_seq_wrap();
    logic ok;
    logic [10:0] ea;
    clear_mon();
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    wr_txn(11'h7FE, 3, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL wrap_acks: got %b want 1", ok); end
    n_checks++;
    if (sq_a.size() != 3) begin
      n_fail++; $display("FAIL wrap_strobe_count: got %0d want 3", sq_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        ea = (11'h7FE + 11'(i)) & 11'h7FF;
        if (sq_a[i] !== ea || sq_d[i] !== wbuf[i]) begin
          n_fail++;
          $display("FAIL wrap_strobe[%0d]: got %h/%h want %h/%h", i, sq_a[i], sq_d[i], ea, wbuf[i]);
        end
      end
    end
  endtask

  task automatic test_wrong_dev();
    logic ack1, ack2;
    clear_mon();
    bus_start();
    send_byte(8'hC0, ack1);
    send_byte(8'hAA, ack2);
    bus_stop();
    n_checks++;
    if (ack1 !== 1'b0 || ack2 !== 1'b0) begin
      n_fail++; $display("FAIL wrongdev_ack: got %b%b want 00", ack1, ack2);
    end
    n_checks++;
    if (oe_seen !== 1'b0 || busy_seen !== 1'b0 || sq_a.size() != 0) begin
      n_fail++;
      $display("FAIL wrongdev_quiet: oe=%b busy=%b strobes=%0d want 0/0/0", oe_seen, busy_seen, sq_a.size());
    end
  endtask

  task automatic test_current_read();
    logic ok;
    logic [10:0] p0;
    p0 = ref_ptr;
    rd_current(3, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL cread_ack: got %b want 1", ok); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rbuf[i] !== ref_mem[p0 + 11'(i)]) begin
        n_fail++;
        $display("FAIL cread_data[%0d]: got %h want %h", i, rbuf[i], ref_mem[p0 + 11'(i)]);
      end
    end
    p0 = ref_ptr;
    rd_current(1, ok);
    n_checks++;
    if (rbuf[0] !== ref_mem[p0]) begin
      n_fail++; $display("FAIL cread_pointer_next: got %h want %h (ptr %h)", rbuf[0], ref_mem[p0], p0);
    end
  endtask

  task automatic test_abort();
    logic ok, ack, r;
    wbuf[0] = 8'h00;
    wr_txn(11'h005, 1, ok);
    clear_mon();
    bus_start();
    send_byte(8'hA0, ack);
    send_byte(8'h05, ack);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, r);
    bus_stop();
    ref_ptr = 11'h005;
    qwait(Q);
    n_checks++;
    if (sq_a.size() != 0 || sda_oe !== 1'b0) begin
      n_fail++; $display("FAIL abort_write: strobes=%0d oe=%b want 0/0", sq_a.size(), sda_oe);
    end
    bus_start();
    send_byte(8'hA1, ack);
    for (int i = 0; i < 3; i++) bit_xfer(1'b1, r);
    sda_m = 1'b1;
    qwait(2);
    n_checks++;
    if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL abort_read_driving: got oe=%b want 1", sda_oe); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (sda_oe !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_reset: oe=%b busy=%b want 0/0", sda_oe, busy);
    end
    qwait(2);
    scl_m = 1'b1;
    qwait(2);
    rst_n = 1'b1;
    ref_ptr = 11'h000;
    qwait(Q);
    rd_current(1, ok);
    n_checks++;
    if (ok !== 1'b1 || rbuf[0] !== ref_mem[11'h000]) begin
      n_fail++; $display("FAIL abort_ptr_reset: ack=%b data=%h want 1/%h", ok, rbuf[0], ref_mem[11'h000]);
    end
  endtask

  task automatic test_random_ops();
    logic ok;
    logic [10:0] a, ra;
    int n, off, rn;
    for (int t = 0; t < 6; t++) begin
      clear_mon();
      a = 11'($urandom_range(0, 2047));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      wr_txn(a, n, ok);
      n_checks++;
      if (ok !== 1'b1 || sq_a.size() != n) begin
        n_fail++; $display("FAIL rnd_write[%0d]: ack=%b strobes=%0d want 1/%0d", t, ok, sq_a.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          if (sq_a[i] !== a + 11'(i) || sq_d[i] !== wbuf[i]) begin
            n_fail++;
            $display("FAIL rnd_strobe[%0d.%0d]: got %h/%h want %h/%h", t, i, sq_a[i], sq_d[i], a + 11'(i), wbuf[i]);
          end
        end
      end
      off = $urandom_range(0, n - 1);
      ra = a + 11'(off);
      rn = $urandom_range(1, n - off);
      rd_random(ra, rn, ok);
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL rnd_read_ack[%0d]: got %b want 1", t, ok); end
      for (int i = 0; i < rn; i++) begin
        n_checks++;
        if (rbuf[i] !== ref_mem[ra + 11'(i)]) begin
          n_fail++;
          $display("FAIL rnd_read[%0d.%0d]: got %h want %h", t, i, rbuf[i], ref_mem[ra + 11'(i)]);
        end
      end
    end
  endtask

  task automatic test_oe_timing();
    n_checks++;
    if (oe_viol != 0) begin
      n_fail++; $display("FAIL oe_while_scl_high: got %0d events want 0", oe_viol);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_single();
    test_random_read();
    test_seq_wrap();
    test_wrong_dev();
    test_current_read();
    test_abort();
    test_random_ops();
    test_oe_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
